// File: rtl/tick_gen_multi.sv
// ---------------------------------------------------------------------------
// tick_gen_multi
//
// Board timebase. Divides the system clock down to a 1 us strobe and a 1 ms
// strobe, and provides N_CH programmable channels. Each channel emits a
// strobe every 2^rate us and a double-rate strobe every 2^(rate-1) us. The
// rate exponent of the channel picked by ch_sel is stepped up or down by
// edge-detected push-buttons.
//
// Optional build macro:
//   BTN_SYNC_EN  - when defined, btn_up, btn_dn and ch_sel each pass through
//                  a two-flop synchroniser before edge detection
//                  (button-to-rate latency 3 clk instead of 1 clk).
//
// Ports:
//   clk      in   1       system clock
//   rst      in   1       asynchronous active-low reset
//   btn_up   in   1       raise selected channel's exponent (slower)
//   btn_dn   in   1       lower selected channel's exponent (faster)
//   ch_sel   in   3       channel targeted by the buttons
//   us_tick  out  1       one-clk strobe every US_DIV clks
//   ms_tick  out  1       one-clk strobe every MS_DIV us_ticks
//   tick     out  N_CH    per-channel strobe, period 2^rate[k] us
//   tick_x2  out  N_CH    per-channel strobe, period 2^(rate[k]-1) us
//   rate_o   out  5*N_CH  current exponents, channel k at [5k+4:5k]
// ---------------------------------------------------------------------------
module tick_gen_multi #(
    parameter int unsigned US_DIV     = 50,
    parameter int unsigned MS_DIV     = 1000,
    parameter int unsigned N_CH       = 2,
    parameter int unsigned CW         = 32,
    parameter int unsigned RATE_RESET = 19,
    parameter int unsigned RATE_MIN   = 9,
    parameter int unsigned RATE_MAX   = 26
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                btn_up,
    input  logic                btn_dn,
    input  logic [2:0]          ch_sel,
    output logic                us_tick,
    output logic                ms_tick,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     tick_x2,
    output logic [5*N_CH-1:0]   rate_o
);

    localparam int unsigned USW = $clog2(US_DIV);
    localparam int unsigned MSW = $clog2(MS_DIV);

    // -----------------------------------------------------------------------
    // 1 us divider
    // -----------------------------------------------------------------------
    logic [USW-1:0] us_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            us_cnt  <= '0;
            us_tick <= 1'b0;
        end else if (us_cnt == USW'(US_DIV - 1)) begin
            us_cnt  <= '0;
            us_tick <= 1'b1;
        end else begin
            us_cnt  <= us_cnt + 1'b1;
            us_tick <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // 1 ms divider, advanced by the registered us strobe
    // -----------------------------------------------------------------------
    logic [MSW-1:0] ms_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ms_cnt  <= '0;
            ms_tick <= 1'b0;
        end else if (us_tick) begin
            if (ms_cnt == MSW'(MS_DIV - 1)) begin
                ms_cnt  <= '0;
                ms_tick <= 1'b1;
            end else begin
                ms_cnt  <= ms_cnt + 1'b1;
                ms_tick <= 1'b0;
            end
        end else begin
            ms_tick <= 1'b0;
        end
    end

    // -----------------------------------------------------------------------
    // Button front end
    // -----------------------------------------------------------------------
    logic       up_in;
    logic       dn_in;
    logic [2:0] sel_in;

`ifdef BTN_SYNC_EN
    logic [1:0] up_sync;
    logic [1:0] dn_sync;
    logic [2:0] sel_s1;
    logic [2:0] sel_s2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_sync <= '0;
            dn_sync <= '0;
            sel_s1  <= '0;
            sel_s2  <= '0;
        end else begin
            up_sync <= {up_sync[0], btn_up};
            dn_sync <= {dn_sync[0], btn_dn};
            sel_s1  <= ch_sel;
            sel_s2  <= sel_s1;
        end
    end

    assign up_in  = up_sync[1];
    assign dn_in  = dn_sync[1];
    assign sel_in = sel_s2;
`else
    assign up_in  = btn_up;
    assign dn_in  = btn_dn;
    assign sel_in = ch_sel;
`endif

    logic up_q;
    logic dn_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            up_q <= 1'b0;
            dn_q <= 1'b0;
        end else begin
            up_q <= up_in;
            dn_q <= dn_in;
        end
    end

    logic up_edge;
    logic dn_edge;

    assign up_edge = up_in & ~up_q;
    assign dn_edge = dn_in & ~dn_q;

    // -----------------------------------------------------------------------
    // Programmable channels
    // -----------------------------------------------------------------------
    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        logic [4:0]    rate;
        logic [CW-1:0] cnt;
        logic          tick_r;
        logic          x2_r;
        logic          sel_hit;
        logic          rate_up;
        logic          rate_dn;
        logic [CW-1:0] full_mask;
        logic [CW-1:0] half_mask;
        logic          at_full;
        logic          at_half;

        // An out-of-range ch_sel matches no channel, so its edges are dropped.
        assign sel_hit = (sel_in == 3'(k));
        assign rate_up = sel_hit & up_edge & ~dn_edge & (rate < 5'(RATE_MAX));
        assign rate_dn = sel_hit & dn_edge & ~up_edge & (rate > 5'(RATE_MIN));

        // Low-bit masks; a shift of CW or more yields an all-ones mask.
        assign full_mask = ~({CW{1'b1}} << rate);
        assign half_mask = ~({CW{1'b1}} << (rate - 5'd1));
        assign at_full   = ((cnt & full_mask) == full_mask);
        assign at_half   = ((cnt & half_mask) == half_mask);

        always_ff @(posedge clk or negedge rst) begin
            if (!rst) begin
                rate   <= 5'(RATE_RESET);
                cnt    <= '0;
                tick_r <= 1'b0;
                x2_r   <= 1'b0;
            end else if (rate_up || rate_dn) begin
                // A real rate change restarts the period and suppresses strobes.
                rate   <= rate_up ? rate + 5'd1 : rate - 5'd1;
                cnt    <= '0;
                tick_r <= 1'b0;
                x2_r   <= 1'b0;
            end else if (us_tick) begin
                cnt    <= at_full ? '0 : cnt + 1'b1;
                tick_r <= at_full;
                x2_r   <= at_half;
            end else begin
                tick_r <= 1'b0;
                x2_r   <= 1'b0;
            end
        end

        assign tick[k]          = tick_r;
        assign tick_x2[k]       = x2_r;
        assign rate_o[5*k +: 5] = rate;
    end

endmodule

// File: tb/tb_tick_gen_multi.sv
module tb_tick_gen_multi;

    localparam int US_DIV     = 4;
    localparam int MS_DIV     = 10;
    localparam int N_CH       = 2;
    localparam int CW         = 8;
    localparam int RATE_RESET = 3;
    localparam int RATE_MIN   = 1;
    localparam int RATE_MAX   = 5;

    logic                clk    = 1'b0;
    logic                rst    = 1'b0;
    logic                btn_up = 1'b0;
    logic                btn_dn = 1'b0;
    logic [2:0]          ch_sel = 3'd0;
    logic                us_tick;
    logic                ms_tick;
    logic [N_CH-1:0]     tick;
    logic [N_CH-1:0]     tick_x2;
    logic [5*N_CH-1:0]   rate_o;

    tick_gen_multi #(
        .US_DIV     (US_DIV),
        .MS_DIV     (MS_DIV),
        .N_CH       (N_CH),
        .CW         (CW),
        .RATE_RESET (RATE_RESET),
        .RATE_MIN   (RATE_MIN),
        .RATE_MAX   (RATE_MAX)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_dn  (btn_dn),
        .ch_sel  (ch_sel),
        .us_tick (us_tick),
        .ms_tick (ms_tick),
        .tick    (tick),
        .tick_x2 (tick_x2),
        .rate_o  (rate_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic              us;
        logic              ms;
        logic [N_CH-1:0]   tk;
        logic [N_CH-1:0]   x2;
        logic [5*N_CH-1:0] rate;
    } exp_t;

    exp_t sbq[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: time is tracked as elapsed clock edges since reset
    // release and elapsed microseconds since each channel's last restart.
    longint m_n;
    int     m_rate [N_CH];
    longint m_u    [N_CH];
    logic   m_up_q, m_dn_q;
    logic [1:0] p_up, p_dn;
    logic [2:0] p_sel [2];

    function automatic logic [5*N_CH-1:0] reset_rates();
        logic [5*N_CH-1:0] r;
        for (int k = 0; k < N_CH; k++) r[5*k +: 5] = 5'(RATE_RESET);
        return r;
    endfunction

    task automatic model_reset();
        m_n    = 0;
        m_up_q = 1'b0;
        m_dn_q = 1'b0;
        p_up   = '0;
        p_dn   = '0;
        p_sel[0] = '0;
        p_sel[1] = '0;
        for (int k = 0; k < N_CH; k++) begin
            m_rate[k] = RATE_RESET;
            m_u[k]    = 0;
        end
    endtask

    // Expected outputs right after the next rising edge, given the inputs
    // that edge samples.
    task automatic model_step(input logic up_i, input logic dn_i,
                              input logic [2:0] sel_i, output exp_t e);
        logic       up, dn, eu, ed, adv, chg;
        logic [2:0] sel;
`ifdef BTN_SYNC_EN
        up = p_up[1]; p_up = {p_up[0], up_i};
        dn = p_dn[1]; p_dn = {p_dn[0], dn_i};
        sel = p_sel[1]; p_sel[1] = p_sel[0]; p_sel[0] = sel_i;
`else
        up = up_i; dn = dn_i; sel = sel_i;
`endif
        m_n = m_n + 1;
        adv  = (m_n - 1 >= US_DIV) && (((m_n - 1) % US_DIV) == 0);
        e.us = ((m_n % US_DIV) == 0);
        e.ms = adv && ((((m_n - 1) / US_DIV) % MS_DIV) == 0);
        eu = up & ~m_up_q;
        ed = dn & ~m_dn_q;
        m_up_q = up;
        m_dn_q = dn;
        for (int k = 0; k < N_CH; k++) begin
            chg = 1'b0;
            if (int'(sel) == k && eu && !ed && m_rate[k] < RATE_MAX) begin
                m_rate[k]++; chg = 1'b1;
            end else if (int'(sel) == k && ed && !eu && m_rate[k] > RATE_MIN) begin
                m_rate[k]--; chg = 1'b1;
            end
            if (chg) begin
                m_u[k]  = 0;
                e.tk[k] = 1'b0;
                e.x2[k] = 1'b0;
            end else if (adv) begin
                m_u[k]  = m_u[k] + 1;
                e.tk[k] = ((m_u[k] % (64'd1 << m_rate[k])) == 0);
                e.x2[k] = ((m_u[k] % (64'd1 << (m_rate[k] - 1))) == 0);
            end else begin
                e.tk[k] = 1'b0;
                e.x2[k] = 1'b0;
            end
            e.rate[5*k +: 5] = 5'(m_rate[k]);
        end
    endtask

    // Drive inputs for the coming edge, queue its expectation, move on.
    task automatic cycle(input logic up, input logic dn, input logic [2:0] sel);
        exp_t e;
        btn_up = up;
        btn_dn = dn;
        ch_sel = sel;
        model_step(up, dn, sel, e);
        sbq.push_back(e);
        @(negedge clk);
    endtask

    task automatic check_reset_state(input string name);
        checks++;
        if ({us_tick, ms_tick, tick, tick_x2} !== '0 || rate_o !== reset_rates()) begin
            failures++;
            $display("FAIL %s: got us=%b ms=%b tick=%b x2=%b rate=%h, expected all strobes 0 rate=%h",
                     name, us_tick, ms_tick, tick, tick_x2, rate_o, reset_rates());
        end
    endtask

    task automatic random_run(input int n);
        logic up = 1'b0, dn = 1'b0;
        logic [2:0] sel = 3'd0;
        for (int i = 0; i < n; i++) begin
            if ($urandom_range(0, 24) == 0) up = ~up;
            if ($urandom_range(0, 24) == 0) dn = ~dn;
            if ($urandom_range(0, 9) == 0)  sel = 3'($urandom_range(0, 7));
            cycle(up, dn, sel);
        end
        for (int i = 0; i < 4; i++) cycle(1'b0, 1'b0, sel);
    endtask

    // Monitor: compare every edge the stimulus queued an expectation for.
    exp_t mon_e;
    exp_t mon_got;
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                mon_e   = sbq.pop_front();
                mon_got = {us_tick, ms_tick, tick, tick_x2, rate_o};
                checks++;
                if (mon_got !== mon_e) begin
                    failures++;
                    $display("FAIL outputs t=%0t: got us=%b ms=%b tick=%b x2=%b rate=%h, expected us=%b ms=%b tick=%b x2=%b rate=%h",
                             $time, mon_got.us, mon_got.ms, mon_got.tk, mon_got.x2, mon_got.rate,
                             mon_e.us, mon_e.ms, mon_e.tk, mon_e.x2, mon_e.rate);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        failures++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        #23;
        check_reset_state("reset_values");
        @(negedge clk);
        rst = 1'b1;

        // Free-running dividers and channels at reset rate.
        for (int i = 0; i < 200; i++) cycle(1'b0, 1'b0, 3'd0);

        // Held button gives one step on channel 0 only.
        for (int i = 0; i < 100; i++) cycle(1'b1, 1'b0, 3'd0);
        for (int i = 0; i < 150; i++) cycle(1'b0, 1'b0, 3'd0);

        // Three up presses on channel 1; the last one saturates.
        for (int p = 0; p < 3; p++) begin
            cycle(1'b1, 1'b0, 3'd1);
            for (int i = 0; i < 45; i++) cycle(1'b0, 1'b0, 3'd1);
        end

        // Four down presses on channel 0; the last one saturates at RATE_MIN.
        for (int p = 0; p < 4; p++) begin
            cycle(1'b0, 1'b1, 3'd0);
            for (int i = 0; i < 21; i++) cycle(1'b0, 1'b0, 3'd0);
        end
        for (int i = 0; i < 60; i++) cycle(1'b0, 1'b0, 3'd0);

        // Simultaneous edges, then an out-of-range channel select.
        cycle(1'b1, 1'b1, 3'd0);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 3'd0);
        cycle(1'b1, 1'b0, 3'd5);
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 3'd5);

        random_run(1500);

        // Asynchronous reset between edges, then asynchronous release.
        btn_up = 1'b0;
        btn_dn = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        check_reset_state("async_reset");
        model_reset();
        repeat (3) @(negedge clk);
        #2;
        check_reset_state("reset_held");
        rst = 1'b1;
        for (int i = 0; i < 20; i++) cycle(1'b0, 1'b0, 3'd0);

        random_run(600);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
